// File: rtl/lcd_bus_rx_if.sv
// HD44780-style LCD write bus (RS/RW/EN/DATA) as seen between controller and responder.
// The master drives every signal; the slave only observes.
interface lcd_bus_rx_if;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] LCD_DATA;

    modport master (output LCD_RS, output LCD_RW, output LCD_EN, output LCD_DATA);
    modport slave  (input  LCD_RS, input  LCD_RW, input  LCD_EN, input  LCD_DATA);
endinterface

// File: rtl/lcd_bus_rx.sv
// Passive LCD bus responder: mirrors a 16x2 character buffer, address counter and display state.
// Optional build macro LCD_RX_TRACE_EN adds evt_cnt, a count of accepted transfers.
//
// state | meaning
// idle  | busy=0, bus transfers evaluated on synced EN fall
// clear | busy=1, one cell blanked per cycle, every transfer rejected
module lcd_bus_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_EN_HIGH = 12,
    parameter int CLR_CYCLES  = 32
) (
    input  logic         CLOCK_50,
    input  logic         KEY,
    lcd_bus_rx_if.slave  bus,
    input  logic [4:0]   rd_addr,
    output logic [7:0]   rd_char,
    output logic [6:0]   ac,
    output logic         disp_on,
    output logic         busy,
    output logic         wr_strobe,
    output logic         cmd_strobe,
    output logic         err
`ifdef LCD_RX_TRACE_EN
    ,
    output logic [15:0]  evt_cnt
`endif
);

    localparam int EW = $clog2(MIN_EN_HIGH + 1);
    localparam int CW = $clog2(CLR_CYCLES);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t          state_q, state_d;
    logic [10:0]     sync_q [SYNC_STAGES];
    logic [10:0]     sync_d [SYNC_STAGES];
    logic            en_prev_q, en_prev_d;
    logic [EW-1:0]   en_cnt_q, en_cnt_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]   clr_idx;
    logic [7:0]      cells_q [32];
    logic [7:0]      cells_d [32];
    logic [7:0]      rd_char_q, rd_char_d;
    logic [6:0]      ac_q, ac_d;
    logic            id_q, id_d;
    logic            disp_on_q, disp_on_d;
    logic            cg_mode_q, cg_mode_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic            cmd_strobe_q, cmd_strobe_d;
    logic            err_q, err_d;
    logic            rs_s, rw_s, en_s, en_fall;
    logic [7:0]      data_s;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Unused DDRAM holes fold back onto the start of their line.
    function automatic logic [6:0] ddram_fold(input logic [6:0] a);
        logic [6:0] r;
        if (a >= 7'h68)      r = 7'h40;
        else if (a >= 7'h40) r = a;
        else if (a >= 7'h28) r = 7'h00;
        else                 r = a;
        return r;
    endfunction

    always_comb begin
        sync_d[0] = {bus.LCD_RS, bus.LCD_RW, bus.LCD_EN, bus.LCD_DATA};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    assign rs_s    = sync_q[SYNC_STAGES-1][10];
    assign rw_s    = sync_q[SYNC_STAGES-1][9];
    assign en_s    = sync_q[SYNC_STAGES-1][8];
    assign data_s  = sync_q[SYNC_STAGES-1][7:0];
    assign en_fall = en_prev_q & ~en_s;
    assign clr_idx = CW'(CLR_CYCLES - 1) - clr_cnt_q;

    always_comb begin
        state_d      = state_q;
        en_prev_d    = en_s;
        clr_cnt_d    = clr_cnt_q;
        cells_d      = cells_q;
        ac_d         = ac_q;
        id_d         = id_q;
        disp_on_d    = disp_on_q;
        cg_mode_d    = cg_mode_q;
        wr_strobe_d  = 1'b0;
        cmd_strobe_d = 1'b0;
        err_d        = 1'b0;
        rd_char_d    = cells_q[rd_addr];

        if (!en_s)                               en_cnt_d = '0;
        else if (en_cnt_q == EW'(MIN_EN_HIGH))   en_cnt_d = en_cnt_q;
        else                                     en_cnt_d = en_cnt_q + EW'(1);

        if (state_q == ST_CLEAR) begin
            if (32'(clr_idx) < 32) cells_d[clr_idx[4:0]] = 8'h20;
            if (clr_cnt_q == '0) state_d = ST_IDLE;
            else                 clr_cnt_d = clr_cnt_q - CW'(1);
        end

        if (en_fall) begin
            if ((en_cnt_q < EW'(MIN_EN_HIGH)) || rw_s || (state_q == ST_CLEAR)) begin
                err_d = 1'b1;
            end else if (rs_s) begin
                wr_strobe_d = 1'b1;
                if (!cg_mode_q) begin
                    if (ac_q[5:4] == 2'b00) cells_d[{ac_q[6], ac_q[3:0]}] = data_s;
                    ac_d = ac_step(ac_q, id_q);
                end
            end else begin
                cmd_strobe_d = 1'b1;
                casez (data_s)
                    8'b1???????: begin
                        cg_mode_d = 1'b0;
                        ac_d      = ddram_fold(data_s[6:0]);
                    end
                    8'b01??????: cg_mode_d = 1'b1;
                    8'b001?????: ;
                    8'b0001????: if (!data_s[3]) ac_d = ac_step(ac_q, data_s[2]);
                    8'b00001???: disp_on_d = data_s[2];
                    8'b000001??: id_d = data_s[1];
                    8'b0000001?: begin
                        ac_d      = 7'h00;
                        cg_mode_d = 1'b0;
                    end
                    8'b00000001: begin
                        state_d   = ST_CLEAR;
                        clr_cnt_d = CW'(CLR_CYCLES - 1);
                        ac_d      = 7'h00;
                        id_d      = 1'b1;
                        cg_mode_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            en_prev_q    <= 1'b0;
            en_cnt_q     <= '0;
            clr_cnt_q    <= '0;
            for (int i = 0; i < 32; i++) cells_q[i] <= 8'h20;
            rd_char_q    <= 8'h20;
            ac_q         <= 7'h00;
            id_q         <= 1'b1;
            disp_on_q    <= 1'b0;
            cg_mode_q    <= 1'b0;
            wr_strobe_q  <= 1'b0;
            cmd_strobe_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            en_prev_q    <= en_prev_d;
            en_cnt_q     <= en_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            for (int i = 0; i < 32; i++) cells_q[i] <= cells_d[i];
            rd_char_q    <= rd_char_d;
            ac_q         <= ac_d;
            id_q         <= id_d;
            disp_on_q    <= disp_on_d;
            cg_mode_q    <= cg_mode_d;
            wr_strobe_q  <= wr_strobe_d;
            cmd_strobe_q <= cmd_strobe_d;
            err_q        <= err_d;
        end
    end

    assign rd_char    = rd_char_q;
    assign ac         = ac_q;
    assign disp_on    = disp_on_q;
    assign busy       = (state_q == ST_CLEAR);
    assign wr_strobe  = wr_strobe_q;
    assign cmd_strobe = cmd_strobe_q;
    assign err        = err_q;

`ifdef LCD_RX_TRACE_EN
    logic [15:0] evt_cnt_q, evt_cnt_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (wr_strobe_q || cmd_strobe_q) evt_cnt_d = evt_cnt_q + 16'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) evt_cnt_q <= 16'd0;
        else      evt_cnt_q <= evt_cnt_d;
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: bus transfers with hand-computed buffer/ac/pulse expectations.
// Covers the evt_cnt trace output when LCD_RX_TRACE_EN is defined.
module tb_lcd_bus_rx;

    logic        CLOCK_50 = 1'b0;
    logic        KEY      = 1'b0;
    logic [4:0]  rd_addr  = 5'd0;
    logic [7:0]  rd_char;
    logic [6:0]  ac;
    logic        disp_on, busy, wr_strobe, cmd_strobe, err;
`ifdef LCD_RX_TRACE_EN
    logic [15:0] evt_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0, cmd_cnt = 0, err_cnt = 0, busy_cycles = 0;
    logic [7:0] v;

    lcd_bus_rx_if bus ();

    lcd_bus_rx dut (
        .CLOCK_50   (CLOCK_50),
        .KEY        (KEY),
        .bus        (bus.slave),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .ac         (ac),
        .disp_on    (disp_on),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .cmd_strobe (cmd_strobe),
        .err        (err)
`ifdef LCD_RX_TRACE_EN
        ,
        .evt_cnt    (evt_cnt)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (wr_strobe)  wr_cnt++;
        if (cmd_strobe) cmd_cnt++;
        if (err)        err_cnt++;
        if (busy)       busy_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int hi);
        @(negedge CLOCK_50);
        bus.LCD_RS   = rs;
        bus.LCD_RW   = rw;
        bus.LCD_DATA = d;
        bus.LCD_EN   = 1'b1;
        repeat (hi) @(negedge CLOCK_50);
        bus.LCD_EN   = 1'b0;
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic cmd(input logic [7:0] d);
        xfer(1'b0, 1'b0, d, 14);
    endtask

    task automatic wr(input logic [7:0] d);
        xfer(1'b1, 1'b0, d, 14);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] c);
        @(negedge CLOCK_50);
        rd_addr = a;
        @(negedge CLOCK_50);
        c = rd_char;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) @(negedge CLOCK_50);
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b0; bus.LCD_DATA = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_ac", ac, 7'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_disp", disp_on, 1'b0);
        chk("rst_rdchar", rd_char, 8'h20);
        chk("rst_pulses", {wr_strobe, cmd_strobe, err}, 3'b000);
        KEY = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        cmd(8'h80); wr(8'h48); wr(8'h49);
        rd(5'd0, v); chk("hi_cell0", v, 8'h48);
        rd(5'd1, v); chk("hi_cell1", v, 8'h49);
        chk("hi_ac", ac, 7'h02);
        chk("hi_wr_cnt", wr_cnt, 2);
        chk("hi_cmd_cnt", cmd_cnt, 1);

        cmd(8'hCF); chk("l1_ac0", ac, 7'h4F);
        wr(8'h41);  chk("l1_ac1", ac, 7'h50);
        wr(8'h41);  chk("l1_ac2", ac, 7'h51);
        rd(5'd31, v); chk("l1_cell31", v, 8'h41);
        rd(5'd16, v); chk("l1_cell16", v, 8'h20);

        cmd(8'h04); cmd(8'h80); wr(8'h5A);
        rd(5'd0, v); chk("dec_cell0", v, 8'h5A);
        chk("dec_ac_wrap", ac, 7'h67);
        cmd(8'h14); chk("shift_wrap", ac, 7'h00);
        cmd(8'h10); chk("shift_dec", ac, 7'h67);
        cmd(8'h0C); chk("disp_on", disp_on, 1'b1);
        cmd(8'hA8); chk("fold_l0", ac, 7'h00);
        cmd(8'hE8); chk("fold_l1", ac, 7'h40);
        cmd(8'h02); chk("home", ac, 7'h00);

        err_cnt = 0; wr_cnt = 0;
        xfer(1'b1, 1'b0, 8'h33, 5);
        chk("short_en_err", err_cnt, 1);
        chk("short_en_ac", ac, 7'h00);
        xfer(1'b1, 1'b1, 8'h33, 14);
        chk("rw_err", err_cnt, 2);
        chk("rej_no_wr", wr_cnt, 0);
        rd(5'd0, v); chk("rej_cell0", v, 8'h5A);

        cmd(8'h06);
        busy_cycles = 0;
        cmd(8'h01);
        chk("clr_busy", busy, 1'b1);
        wait_idle("clr_done");
        chk("clr_len", busy_cycles, 32);
        chk("clr_ac", ac, 7'h00);
        rd(5'd0, v);  chk("clr_cell0", v, 8'h20);
        rd(5'd1, v);  chk("clr_cell1", v, 8'h20);
        rd(5'd31, v); chk("clr_cell31", v, 8'h20);
        wr(8'h55);
        rd(5'd0, v); chk("post_clr_cell0", v, 8'h55);
        chk("post_clr_ac", ac, 7'h01);

        err_cnt = 0;
        cmd(8'h01);
        wr(8'h77);
        chk("busy_err", err_cnt, 1);
        wait_idle("clr2_done");
        chk("busy_ac", ac, 7'h00);
        rd(5'd0, v); chk("busy_cell0", v, 8'h20);

        cmd(8'h01);
        repeat (3) @(negedge CLOCK_50);
        chk("mid_busy", busy, 1'b1);
        #3 KEY = 1'b0;
        #2 chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_disp", disp_on, 1'b0);
        repeat (2) @(negedge CLOCK_50);
        KEY = 1'b1;
        repeat (2) @(negedge CLOCK_50);

`ifdef LCD_RX_TRACE_EN
        chk("evt_rst", evt_cnt, 16'd0);
        cmd(8'h80); wr(8'h31); wr(8'h32);
        xfer(1'b1, 1'b0, 8'h33, 5);
        chk("evt_cnt", evt_cnt, 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
